// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and result-flag bundle for alu_pipe.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_EQ   = 4'b1111;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic neg;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Shift-add iterative unsigned multiplier: one partial product per cycle, WIDTH cycles per op.
module alu_pipe_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // The final partial product is folded in combinationally so the result lands on the last edge.
  assign product  = acc_next;
  assign done     = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and tag pass-through.
// Define ALU_PIPE_MUL_EN to enable the iterative multiply (opcode 1010).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_neg,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flags;

  assign shamt = in_b[SHAMT_W-1:0];
  assign sum   = {1'b0, in_a} + {1'b0, in_b};
  assign diff  = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (in_op)
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_ADD: begin
        alu_res            = sum[WIDTH-1:0];
        alu_flags.carry    = sum[WIDTH];
        alu_flags.overflow = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                             (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res            = diff[WIDTH-1:0];
        alu_flags.carry    = diff[WIDTH];
        alu_flags.overflow = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                             (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $signed(in_a) >>> shamt;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      // MUL is handled by the multiplier path; without it, it lands here as illegal.
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[WIDTH-1];
  end

  logic             accept;
  logic             is_mul;
  logic             load;
  logic [WIDTH-1:0] load_res;
  flags_t           load_flags;
  logic [TAG_W-1:0] load_tag;

  assign accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  state_e             state_q, state_d;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [TAG_W-1:0]   mul_tag_q;

  assign is_mul    = (in_op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign busy      = (state_q == MUL_BUSY);
  assign in_ready  = !rst && (state_q == IDLE) && (!out_valid || out_ready);

  alu_pipe_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mul_start) state_d = MUL_BUSY;
      MUL_BUSY: if (mul_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mul_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) mul_tag_q <= in_tag;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign busy     = 1'b0;
  assign in_ready = !rst && (!out_valid || out_ready);
`endif

  always_comb begin
    load       = accept && !is_mul;
    load_res   = alu_res;
    load_flags = alu_flags;
    load_tag   = in_tag;
`ifdef ALU_PIPE_MUL_EN
    // Output register is empty here: acceptance required it to be empty or draining.
    if (busy && mul_done) begin
      load                = 1'b1;
      load_res            = mul_prod[WIDTH-1:0];
      load_flags          = '0;
      load_flags.overflow = (mul_prod[2*WIDTH-1:WIDTH] != '0);
      load_flags.zero     = (mul_prod[WIDTH-1:0] == '0);
      load_flags.neg      = mul_prod[WIDTH-1];
      load_tag            = mul_tag_q;
    end
`endif
  end

  flags_t flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      flags_q    <= '0;
      out_tag    <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_result <= load_res;
      flags_q    <= load_flags;
      out_tag    <= load_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_carry    = flags_q.carry;
  assign out_zero     = flags_q.zero;
  assign out_overflow = flags_q.overflow;
  assign out_neg      = flags_q.neg;
  assign out_err      = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32, TAG_W=4).
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_overflow;
  logic        out_neg;
  logic        out_err;
  logic [3:0]  out_tag;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(
    .WIDTH (32),
    .TAG_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_neg      (out_neg),
    .out_err      (out_err),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Check a full registered result: valid, value, flags {carry,zero,ovf,neg,err}, tag.
  task automatic check_out(input string name, input logic [31:0] res, input logic c,
                           input logic z, input logic v, input logic n, input logic e,
                           input logic [3:0] tag);
    chk({name, ".valid"}, 64'(out_valid), 64'(1));
    chk({name, ".result"}, 64'(out_result), 64'(res));
    chk({name, ".flags"},
        64'({out_carry, out_zero, out_overflow, out_neg, out_err}),
        64'({c, z, v, n, e}));
    chk({name, ".tag"}, 64'(out_tag), 64'(tag));
  endtask

  // Offer one op for exactly one edge; inputs change #1 after the edge.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    chk({name, ".in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_mul(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", 64'(out_valid), 64'(0));
    chk("reset.in_ready", 64'(in_ready), 64'(0));
    chk("reset.result", 64'(out_result), 64'(0));
    chk("reset.flags", 64'({out_carry, out_zero, out_overflow, out_neg, out_err}), 64'(0));
    chk("reset.tag", 64'(out_tag), 64'(0));
    chk("reset.busy", 64'(busy), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_reset.in_ready", 64'(in_ready), 64'(1));

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 4'h1);
    check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1);
    run_op("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'h2);
    check_out("add_carry", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    run_op("sub_eq", OP_SUB, 32'd5, 32'd5, 4'h3);
    check_out("sub_eq", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    run_op("sub_borrow", OP_SUB, 32'd3, 32'd5, 4'h4);
    check_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4);
    run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 4'h5);
    check_out("slt", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
    run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 4'h6);
    check_out("sltu", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'h21, 4'h7);
    check_out("sra", 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
    run_op("srl", OP_SRL, 32'h8000_0000, 32'h4, 4'h8);
    check_out("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8);
    run_op("sll", OP_SLL, 32'h1, 32'h1F, 4'h9);
    check_out("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9);
    run_op("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'hA);
    check_out("xor", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);
    run_op("nor", OP_NOR, 32'h0, 32'h0, 4'hB);
    check_out("nor", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB);
    run_op("eq_true", OP_EQ, 32'h1234, 32'h1234, 4'hC);
    check_out("eq_true", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC);
    run_op("eq_false", OP_EQ, 32'h1234, 32'h1235, 4'hD);
    check_out("eq_false", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD);
    run_op("illegal", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hE);
    check_out("illegal", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hE);

    // Four back-to-back ANDs, one result per cycle, tags in order.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_op    = OP_AND;
      in_a     = 32'hF0 | 32'(i);
      in_b     = 32'hFF;
      in_tag   = 4'(8 + i);
      chk("stream.in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      chk("stream.valid", 64'(out_valid), 64'(1));
      chk("stream.result", 64'(out_result), 64'(32'hF0 | 32'(i)));
      chk("stream.tag", 64'(out_tag), 64'(8 + i));
    end

    // Backpressure: result held, new op waits until the consumer drains.
    in_op     = OP_OR;
    in_a      = 32'h1;
    in_b      = 32'h2;
    in_tag    = 4'h3;
    out_ready = 1'b0;
    #1;
    chk("stall.in_ready", 64'(in_ready), 64'(0));
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("stall.valid", 64'(out_valid), 64'(1));
      chk("stall.result", 64'(out_result), 64'(32'hF3));
      chk("stall.tag", 64'(out_tag), 64'(4'hB));
      chk("stall.in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("drain.in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_out("drain_accept", 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
    @(posedge clk);
    #1;
    chk("drained.valid", 64'(out_valid), 64'(0));

`ifdef ALU_PIPE_MUL_EN
    run_op("mul_big", OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'h5);
    chk("mul_big.in_ready", 64'(in_ready), 64'(0));
    chk("mul_big.pending", 64'(out_valid), 64'(0));
    wait_mul(n);
    chk("mul_big.cycles", 64'(n), 64'(32));
    check_out("mul_big", 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    run_op("mul_small", OP_MUL, 32'd7, 32'd6, 4'h6);
    wait_mul(n);
    chk("mul_small.cycles", 64'(n), 64'(32));
    check_out("mul_small", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6);

    // Reset during cycle 10 of a multiply aborts it with no result.
    run_op("mul_abort", OP_MUL, 32'h1234, 32'h5678, 4'h7);
    repeat (9) @(posedge clk);
    #1;
    chk("mul_abort.busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("mul_abort.busy", 64'(busy), 64'(0));
    chk("mul_abort.valid", 64'(out_valid), 64'(0));
    chk("mul_abort.in_ready_rst", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mul_abort.in_ready", 64'(in_ready), 64'(1));
    repeat (40) @(posedge clk);
    #1;
    chk("mul_abort.no_result", 64'(out_valid), 64'(0));
    chk("mul_abort.idle", 64'(busy), 64'(0));
`else
    run_op("mul_off", OP_MUL, 32'd7, 32'd6, 4'h2);
    check_out("mul_off", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2);
    chk("mul_off.busy", 64'(busy), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
